// File: rtl/sha_host_pkg.sv
// Shared types and constants for the SHA-256 job host: FSM state encoding,
// default job sizes and the word returned for out-of-range core reads.
package sha_host_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int MSG_WORDS_DEF    = 20;
  localparam int DIGEST_WORDS_DEF = 8;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/sha_word_ram.sv
// Single-port word RAM: synchronous write, registered write-first read.
// Only the read register is reset; the array contents survive reset.
module sha_word_ram #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_comb begin
    rdata_d = we ? wdata : mem[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sha_job_host.sv
// Host-side job controller for the SHA-256 core: load message, start, serve core memory, drain digest.
// Optional macro SHA_HOST_ADDR_CHECK_EN flags, drops and poisons core accesses at or beyond DEPTH.
//
// state | meaning
// LOAD  | accepting message words from the upstream stream into the RAM
// START | one-cycle start pulse to the core
// WAIT  | core owns the RAM port; waiting for a fresh rising edge of sha_done
// DRAIN | streaming digest words out of the RAM
import sha_host_pkg::*;

module sha_job_host #(
  parameter int          DEPTH        = 64,
  parameter int          MSG_WORDS    = MSG_WORDS_DEF,
  parameter int          DIGEST_WORDS = DIGEST_WORDS_DEF,
  parameter logic [15:0] MSG_BASE     = 16'h0000,
  parameter logic [15:0] OUT_BASE     = 16'h0020
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        addr_err,
  output logic        sha_start,
  output logic [15:0] sha_message_addr,
  output logic [15:0] sha_output_addr,
  input  logic        sha_done,
  input  logic        sha_mem_we,
  input  logic [15:0] sha_mem_addr,
  input  logic [31:0] sha_mem_write_data,
  output logic [31:0] sha_mem_read_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = 16;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             done_prev_q, done_prev_d;

  logic             in_hs, out_hs, done_rise, core_owns, addr_oob;
  logic [15:0]      host_addr;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [31:0]      ram_wdata, ram_rdata, rd_data;
  logic             unused_addr_bits;

  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid_q & out_ready;
  assign done_rise = sha_done & ~done_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      done_prev_q <= done_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_prev_d = sha_done;
    case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          if (cnt_q == CNT_W'(MSG_WORDS - 1)) begin
            state_d = ST_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_rise) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (out_hs) begin
          if (cnt_q == CNT_W'(DIGEST_WORDS - 1)) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    endcase
    // Valid only from the second DRAIN cycle on, once the first read has landed.
    out_valid_d = (state_q == ST_DRAIN) && (state_d == ST_DRAIN);
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    sha_start = (state_q == ST_START);
    busy      = (state_q != ST_LOAD);
  end

  // Drain reads follow the next count so a handshake is immediately followed by the next word.
  always_comb begin
    core_owns = (state_q == ST_START) || (state_q == ST_WAIT);
    host_addr = (state_q == ST_DRAIN) ? OUT_BASE + cnt_d : MSG_BASE + cnt_q;
    ram_addr  = core_owns ? sha_mem_addr[AW-1:0] : host_addr[AW-1:0];
    ram_wdata = core_owns ? sha_mem_write_data : in_data;
    ram_we    = 1'b0;
    case (state_q)
      ST_LOAD: ram_we = in_hs;
      ST_WAIT: ram_we = sha_mem_we & ~addr_oob;
      default: ram_we = 1'b0;
    endcase
  end

  sha_word_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

`ifdef SHA_HOST_ADDR_CHECK_EN
  logic addr_err_q, addr_err_d, rd_oob_q, rd_oob_d;

  assign addr_oob = (state_q == ST_WAIT) && (32'(sha_mem_addr) >= 32'(DEPTH));

  always_comb begin
    addr_err_d = addr_err_q | addr_oob;
    rd_oob_d   = addr_oob;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
      rd_oob_q   <= rd_oob_d;
    end
  end

  assign addr_err = addr_err_q;
  assign rd_data  = rd_oob_q ? ERR_WORD : ram_rdata;
`else
  assign addr_oob = 1'b0;
  assign addr_err = 1'b0;
  assign rd_data  = ram_rdata;
`endif

  assign unused_addr_bits  = ^{host_addr[15:AW], sha_mem_addr[15:AW]};

  assign out_valid         = out_valid_q;
  assign out_data          = rd_data;
  assign sha_mem_read_data = rd_data;
  assign sha_message_addr  = MSG_BASE;
  assign sha_output_addr   = OUT_BASE;

endmodule

// File: tb/tb_sha_job_host.sv
// Self-checking bench for sha_job_host: a stub SHA core drives the memory bus,
// digest words are queued when written and compared as they drain.
module tb_sha_job_host;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy, addr_err, sha_start;
  logic [15:0] sha_message_addr, sha_output_addr;
  logic        sha_done = 1'b0;
  logic        sha_mem_we = 1'b0;
  logic [15:0] sha_mem_addr = '0;
  logic [31:0] sha_mem_write_data = '0;
  logic [31:0] sha_mem_read_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  sha_job_host dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .addr_err(addr_err), .sha_start(sha_start),
    .sha_message_addr(sha_message_addr), .sha_output_addr(sha_output_addr),
    .sha_done(sha_done), .sha_mem_we(sha_mem_we), .sha_mem_addr(sha_mem_addr),
    .sha_mem_write_data(sha_mem_write_data), .sha_mem_read_data(sha_mem_read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes 20 words base+k; leaves the DUT in START.
  task automatic push_words(input logic [31:0] base);
    int n = 0;
    int guard = 0;
    in_valid = 1'b1;
    while (n < 20 && guard < 100) begin
      in_data = base + 32'(n);
      if (in_ready) n++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL load_accept: accepted %0d words, required 20", n);
    end
  endtask

  task automatic core_write(input logic [15:0] a, input logic [31:0] d);
    sha_mem_we = 1'b1;
    sha_mem_addr = a;
    sha_mem_write_data = d;
    tick();
    sha_mem_we = 1'b0;
  endtask

  // Drains until the scoreboard empties; toggle=1 gives out_ready 1,0,1,0...
  task automatic drain_all(input bit toggle, output int ncyc);
    bit          stalled = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] exp;
    ncyc = 0;
    while (sb.size() > 0 && ncyc < 100) begin
      out_ready = toggle ? ~ncyc[0] : 1'b1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          $display("FAIL drain_stall_hold: valid=%b data=%h, required valid=1 data=%h",
                   out_valid, out_data, held);
        end
        stalled = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          exp = sb.pop_front();
          checks++;
          if (out_data !== exp) begin
            errors++;
            $display("FAIL drain_word: got %h, required %h", out_data, exp);
          end
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      tick();
      ncyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words still expected", sb.size());
      sb.delete();
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_return: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
               in_ready, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0 ||
        sha_start !== 1'b0 || sha_mem_read_data !== 32'h0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%h busy=%b start=%b rd=%h err=%b",
               in_ready, out_valid, out_data, busy, sha_start, sha_mem_read_data, addr_err);
    end
    tick();
    tick();
    #3;
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: busy=%b in_ready=%b, required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_load();
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = 32'(k);
      checks++;
      if (in_ready !== 1'b1 || sha_start !== 1'b0) begin
        errors++;
        $display("FAIL load_ready: word %0d in_ready=%b start=%b, required 1 0", k, in_ready, sha_start);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || sha_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_start: in_ready=%b start=%b busy=%b, required 0 1 1", in_ready, sha_start, busy);
    end
    checks++;
    if (sha_message_addr !== 16'h0000 || sha_output_addr !== 16'h0020) begin
      errors++;
      $display("FAIL base_addrs: msg=%h out=%h, required 0000 0020", sha_message_addr, sha_output_addr);
    end
    tick();
    checks++;
    if (sha_start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse: start=%b in_ready=%b busy=%b, required 0 0 1", sha_start, in_ready, busy);
    end
  endtask

  task automatic test_core_read();
    sha_mem_addr = 16'h0005;
    tick();
    checks++;
    if (sha_mem_read_data !== 32'h0000_0005) begin
      errors++;
      $display("FAIL core_read_5: got %h, required 00000005", sha_mem_read_data);
    end
    sha_mem_addr = 16'h0013;
    tick();
    checks++;
    if (sha_mem_read_data !== 32'h0000_0013) begin
      errors++;
      $display("FAIL core_read_13: got %h, required 00000013", sha_mem_read_data);
    end
    core_write(16'h0005, 32'hCAFE_F00D);
    checks++;
    if (sha_mem_read_data !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL write_first: got %h, required cafef00d", sha_mem_read_data);
    end
    sha_mem_addr = 16'h0013;
    tick();
    sha_mem_addr = 16'h0005;
    tick();
    checks++;
    if (sha_mem_read_data !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL core_readback: got %h, required cafef00d", sha_mem_read_data);
    end
  endtask

  task automatic test_drain_backpressure();
    int n;
    for (int i = 0; i < 8; i++) begin
      core_write(16'h0020 + 16'(i), 32'h1111_1111 * 32'(i + 1));
      sb.push_back(32'h1111_1111 * 32'(i + 1));
    end
    sha_done = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_latency1: out_valid=%b busy=%b, required 0 1", out_valid, busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_latency2: out_valid=%b, required 1", out_valid);
    end
    drain_all(1'b1, n);
  endtask

  task automatic test_stale_done();
    int n;
    int early = 0;
    push_words(32'h40);
    checks++;
    if (sha_start !== 1'b1 || sha_done !== 1'b1) begin
      errors++;
      $display("FAIL stale_start: start=%b, required 1", sha_start);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (out_valid !== 1'b0) early++;
    end
    sha_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      core_write(16'h0020 + 16'(i), 32'hA000_0000 + 32'(i * 3));
      sb.push_back(32'hA000_0000 + 32'(i * 3));
      if (out_valid !== 1'b0) early++;
    end
    sha_mem_addr = 16'h0005;
    tick();
    checks++;
    if (sha_mem_read_data !== 32'h0000_0045) begin
      errors++;
      $display("FAIL reload_read: got %h, required 00000045", sha_mem_read_data);
    end
    tick();
    if (out_valid !== 1'b0) early++;
    checks++;
    if (early != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stale_ignored: %0d early valid cycles busy=%b, required 0 and 1", early, busy);
    end
    sha_done = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_latency1: out_valid=%b, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stale_latency2: out_valid=%b, required 1", out_valid);
    end
    drain_all(1'b0, n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL back_to_back: drain took %0d valid cycles, required 8", n);
    end
  endtask

  task automatic test_addr_check();
    logic [31:0] exp_oob_rd, exp_rd0;
    logic        exp_err;
`ifdef SHA_HOST_ADDR_CHECK_EN
    exp_oob_rd = 32'hDEAD_BEEF;
    exp_rd0    = 32'h0000_0100;
    exp_err    = 1'b1;
`else
    exp_oob_rd = 32'h0000_0100;
    exp_rd0    = 32'h1234_5678;
    exp_err    = 1'b0;
`endif
    push_words(32'h100);
    tick();
    sha_mem_addr = 16'h0040;
    tick();
    checks++;
    if (sha_mem_read_data !== exp_oob_rd || addr_err !== exp_err) begin
      errors++;
      $display("FAIL oob_read: rd=%h err=%b, required %h %b", sha_mem_read_data, addr_err, exp_oob_rd, exp_err);
    end
    core_write(16'h0040, 32'h1234_5678);
    sha_mem_addr = 16'h0000;
    tick();
    checks++;
    if (sha_mem_read_data !== exp_rd0 || addr_err !== exp_err) begin
      errors++;
      $display("FAIL oob_write: rd0=%h err=%b, required %h %b", sha_mem_read_data, addr_err, exp_rd0, exp_err);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (addr_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sha_mem_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wait: err=%b busy=%b in_ready=%b rd=%h, required 0 0 1 0",
               addr_err, busy, in_ready, sha_mem_read_data);
    end
    tick();
    #3;
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: busy=%b in_ready=%b out_valid=%b, required 0 1 0",
               busy, in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_core_read();
    test_drain_backpressure();
    test_stale_done();
    test_addr_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_job_host.md
# sha_job_host

Host-side job controller and memory responder for the SHA-256 hashing core. It accepts message words from an upstream valid/ready stream and stores them in an internal word RAM, then pulses `start` to the core. While the core runs, it serves the core's memory bus as the responding end, with one-cycle read latency. On `done` it streams the digest words back out on a downstream valid/ready stream.

## Interface
- `DEPTH`, 64: RAM depth in 32-bit words; power of two, ≥ 64.
- `MSG_WORDS`, 20: message words accepted per job.
- `DIGEST_WORDS`, 8: digest words streamed out per job.
- `MSG_BASE`, 16'h0000: word address driven on `sha_message_addr`; base for host writes.
- `OUT_BASE`, 16'h0020: word address driven on `sha_output_addr`; base for the digest drain.

- `clk`  in  1  clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  32  upstream message word.
- `in_ready`  out  1  block accepts a word this cycle.
- `out_valid`  out  1  digest word valid.
- `out_data`  out  32  digest word.
- `out_ready`  in  1  downstream accepts.
- `busy`  out  1  high in START, WAIT and DRAIN.
- `addr_err`  out  1  sticky out-of-range access flag (see Configuration).
- `sha_start`  out  1  one-cycle start pulse to the core.
- `sha_message_addr`, `sha_output_addr`  out  16  constant `MSG_BASE` / `OUT_BASE`.
- `sha_done`  in  1  core done level; stays high after completion until the next start.
- `sha_mem_we`  in  1  core write enable.
- `sha_mem_addr`  in  16  core word address.
- `sha_mem_write_data`  in  32  core write data.
- `sha_mem_read_data`  out  32  registered RAM read data.

## Operation
- FSM states: LOAD, START, WAIT, DRAIN.
- LOAD
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) writes `in_data` to `MSG_BASE`+cnt, then cnt++.
  - On the handshake with cnt=`MSG_WORDS`-1: move to START; `in_ready` drops the next cycle.
- START
  - `sha_start`=1 for exactly this one cycle; go to WAIT.
- WAIT
  - RAM port owned by the core.
  - When `sha_mem_we`=1, write `sha_mem_write_data` at `sha_mem_addr`.
  - Completion is the rising edge of `sha_done` (the flag is compared against its value registered on the previous cycle). A stale high `sha_done` left over from the previous job is ignored until it falls and rises again.
  - On the edge: go to DRAIN with cnt=0.
- DRAIN
  - Read `OUT_BASE`+cnt; present the word with `out_valid`=1.
  - `out_data` is held stable while `out_valid`&!`out_ready`.
  - Each handshake advances cnt. After handshake `DIGEST_WORDS`-1, return to LOAD with cnt=0.
- Core writes outside WAIT are ignored.
- RAM address index is `addr[$clog2(DEPTH)-1:0]`.
- A write and a read to the same address on the same cycle return the new data (write-first).
- Reset (asynchronous, any state, including mid-WAIT or mid-DRAIN):
  - FSM→LOAD, cnt=0.
  - `in_ready`=1; `out_valid`, `out_data`, `busy`, `sha_start`, `sha_mem_read_data`, `addr_err` = 0.
  - RAM contents are not reset.

## Timing
- Core read: `sha_mem_addr` sampled at edge N; data valid on `sha_mem_read_data` after edge N, i.e. during cycle N+1. The read is always performed in every state (address mux: core address in START/WAIT, host address otherwise).
- Final LOAD handshake at edge N: `sha_start`=1 during cycle N+1 only.
- Drain: first `out_valid` two cycles after the `sha_done` rising edge is sampled (one cycle for the state change, one for the RAM read). Back-to-back words at one per cycle when `out_ready`=1.
- Total drain with `out_ready` constantly 1: `DIGEST_WORDS`+1 cycles.

## Configuration
- `SHA_HOST_ADDR_CHECK_EN` defined:
  - Any access in WAIT with `sha_mem_addr`≥`DEPTH` sets `addr_err` (sticky until reset).
  - Such a write is dropped.
  - Such a read returns 32'hDEADBEEF.
- Undefined:
  - Addresses wrap modulo `DEPTH`.
  - `addr_err` is tied to 0.

## Structure
- Package `sha_host_pkg` holds:
  - the FSM state enum type;
  - the `MSG_WORDS` and `DIGEST_WORDS` defaults;
  - the constant 32'hDEADBEEF error word.
- Sub-module `sha_word_ram`: single-port, synchronous write, registered write-first read, parameter `DEPTH`. The FSM, address/data muxing and done-edge detection live in the top.

## Test plan
- Reset: assert `reset_n`=0 mid-cycle → all outputs 0 and `in_ready`=1 immediately; `busy`=0 after release.
- Load: push 0x00000000..0x00000013 with `in_valid` held high → `in_ready` low from the cycle after the 20th handshake. `sha_start` high for exactly one cycle, one cycle after the 20th handshake. `sha_message_addr`=0x0000 and `sha_output_addr`=0x0020 throughout.
- Core read: stub core drives `sha_mem_addr`=0x0005 at edge N → `sha_mem_read_data`=0x00000005 after edge N (cycle N+1). Write 0xCAFEF00D to 0x0005, read it the next cycle → 0xCAFEF00D.
- Drain with backpressure:
  - Stimulus: stub writes 0x11111111..0x88888888 to 0x20..0x27, then raises `sha_done`; `out_ready` toggles 1,0,1,0.
  - Required: 8 words emitted in order, `out_data` stable during stalls, then LOAD.
- Stale done: `sha_done` high at START, falling after 3 cycles and rising 10 cycles later → no `out_valid` before the rise; drain starts two cycles after the rise.
- Address check: stub accesses 0x0040 in WAIT → with the macro, `addr_err`=1 and read returns 0xDEADBEEF; without the macro, the read returns the word at 0x0000 and `addr_err`=0.
